// File: rtl/reg_pipe.sv
// reg_pipe: elastic pipeline register of DEPTH word-wide stages with a
// valid/ready handshake on both ends, bubble collapsing and backpressure.
// Ports:
//   clk        rising-edge clock
//   sclr       synchronous active-high clear (discards all held words)
//   in_valid   upstream word valid
//   in_ready   stage 0 can accept this cycle (combinational, forced low by sclr)
//   in_data    upstream word
//   out_valid  last stage holds a word (registered)
//   out_ready  downstream accepts this cycle
//   out_data   word held in the last stage (registered)
//   occupancy  number of valid stages, 0..DEPTH (registered)
module reg_pipe #(
   parameter int unsigned Width = 32,
   parameter int unsigned DEPTH = 2
) (
   input  logic                       clk,
   input  logic                       sclr,
   input  logic                       in_valid,
   output logic                       in_ready,
   input  logic [Width-1:0]           in_data,
   output logic                       out_valid,
   input  logic                       out_ready,
   output logic [Width-1:0]           out_data,
   output logic [$clog2(DEPTH+1)-1:0] occupancy
);

   localparam int unsigned OccW = $clog2(DEPTH + 1);

   logic [DEPTH-1:0]            vld_q, vld_d;
   logic [DEPTH-1:0][Width-1:0] dat_q, dat_d;
   logic [OccW-1:0]             occ_q, occ_d;
   logic [DEPTH-1:0]            rdy;
   logic                        push;
   logic                        pop;

   // Ready chain: a stage can load if it is empty or its successor can load.
   always_comb begin
      rdy = '0;
      rdy[DEPTH-1] = ~vld_q[DEPTH-1] | out_ready;
      for (int i = int'(DEPTH) - 2; i >= 0; i--) begin
         rdy[i] = ~vld_q[i] | rdy[i+1];
      end
   end

   // Stage advance; data only loads with a valid word so empty stages keep old data.
   always_comb begin
      vld_d = vld_q;
      dat_d = dat_q;
      if (rdy[0]) begin
         vld_d[0] = in_valid;
         if (in_valid) begin
            dat_d[0] = in_data;
         end
      end
      for (int i = 1; i < int'(DEPTH); i++) begin
         if (rdy[i]) begin
            vld_d[i] = vld_q[i-1];
            if (vld_q[i-1]) begin
               dat_d[i] = dat_q[i-1];
            end
         end
      end
      push  = in_valid & rdy[0];
      pop   = vld_q[DEPTH-1] & out_ready;
      occ_d = occ_q + OccW'(push) - OccW'(pop);
   end

   // State registers with synchronous clear.
   always_ff @(posedge clk) begin
      if (sclr) begin
         vld_q <= '0;
         dat_q <= '0;
         occ_q <= '0;
      end else begin
         vld_q <= vld_d;
         dat_q <= dat_d;
         occ_q <= occ_d;
      end
   end

   assign in_ready  = rdy[0] & ~sclr;
   assign out_valid = vld_q[DEPTH-1];
   assign out_data  = dat_q[DEPTH-1];
   assign occupancy = occ_q;

endmodule

// File: tb/tb_reg_pipe.sv
// tb_reg_pipe: directed vector table plus randomized scoreboard run for reg_pipe
// (Width=32, DEPTH=3).
module tb_reg_pipe;

   localparam int unsigned W = 32;
   localparam int unsigned D = 3;

   logic         clk;
   logic         sclr;
   logic         in_valid;
   logic         in_ready;
   logic [W-1:0] in_data;
   logic         out_valid;
   logic         out_ready;
   logic [W-1:0] out_data;
   logic [1:0]   occupancy;

   int n_checks = 0;
   int n_fail   = 0;

   typedef struct {
      logic         sclr;
      logic         iv;
      logic [W-1:0] id;
      logic         ordy;
      logic         e_irdy;   // in_ready before the edge
      logic         e_ov;     // outputs after the edge
      logic [W-1:0] e_od;
      logic [1:0]   e_occ;
   } vec_t;

   vec_t     vecs[$];
   logic [W-1:0] sb[$];

   reg_pipe #(.Width(W), .DEPTH(D)) dut (
      .clk       (clk),
      .sclr      (sclr),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .occupancy (occupancy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic add(input logic s, input logic iv, input logic [W-1:0] id, input logic ordy,
                      input logic e_irdy, input logic e_ov, input logic [W-1:0] e_od,
                      input logic [1:0] e_occ);
      vec_t v;
      v.sclr = s; v.iv = iv; v.id = id; v.ordy = ordy;
      v.e_irdy = e_irdy; v.e_ov = e_ov; v.e_od = e_od; v.e_occ = e_occ;
      vecs.push_back(v);
   endtask

   initial begin
      logic         exp_irdy;
      logic         do_push;
      logic         do_pop;
      logic [W-1:0] wdata;
      int           budget;

      sclr = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;

      //   sclr iv id   ordy | irdy ov od  occ
      // Reset with in_valid held high
      add(1, 1, 99, 0,  0, 0, 0,  0);
      add(1, 1, 99, 0,  0, 0, 0,  0);
      add(1, 1, 99, 0,  0, 0, 0,  0);
      add(0, 0, 0,  0,  1, 0, 0,  0);
      // Latency of a single word
      add(0, 1, 34, 1,  1, 0, 0,  1);
      add(0, 0, 0,  1,  1, 0, 0,  1);
      add(0, 0, 0,  1,  1, 1, 34, 1);
      add(0, 0, 0,  1,  1, 0, 34, 0);
      // Fill and stall, then full push+pop and drain
      add(0, 1, 1,  0,  1, 0, 34, 1);
      add(0, 1, 2,  0,  1, 0, 34, 2);
      add(0, 1, 3,  0,  1, 1, 1,  3);
      add(0, 1, 4,  0,  0, 1, 1,  3);
      add(0, 1, 4,  1,  1, 1, 2,  3);
      add(0, 0, 0,  1,  1, 1, 3,  2);
      add(0, 0, 0,  1,  1, 1, 4,  1);
      add(0, 0, 0,  1,  1, 0, 4,  0);
      // Bubble collapse
      add(0, 1, 5,  0,  1, 0, 4,  1);
      add(0, 0, 0,  0,  1, 0, 4,  1);
      add(0, 1, 6,  0,  1, 1, 5,  2);
      add(0, 0, 0,  0,  1, 1, 5,  2);
      add(0, 0, 0,  0,  1, 1, 5,  2);
      // Mid-stream clear, then a lone word
      add(1, 1, 77, 0,  0, 0, 0,  0);
      add(0, 1, 32, 1,  1, 0, 0,  1);
      add(0, 0, 0,  1,  1, 0, 0,  1);
      add(0, 0, 0,  1,  1, 1, 32, 1);
      add(0, 0, 0,  1,  1, 0, 32, 0);

      foreach (vecs[k]) begin
         sclr = vecs[k].sclr; in_valid = vecs[k].iv;
         in_data = vecs[k].id; out_ready = vecs[k].ordy;
         #1;
         check($sformatf("v%0d in_ready", k), W'(in_ready), W'(vecs[k].e_irdy));
         @(posedge clk); #1;
         check($sformatf("v%0d out_valid", k), W'(out_valid), W'(vecs[k].e_ov));
         check($sformatf("v%0d out_data", k), out_data, vecs[k].e_od);
         check($sformatf("v%0d occupancy", k), W'(occupancy), W'(vecs[k].e_occ));
      end

      // Bubble collapse follow-up: 5 then 6 on consecutive cycles
      sclr = 0; in_valid = 0; out_ready = 0;
      add(0, 0, 0, 0, 0, 0, 0, 0);
      @(posedge clk); #1;
      add(0, 0, 0, 0, 0, 0, 0, 0);
      // state now: empty after clear sequence; rebuild 5/gap/6 and pop
      in_valid = 1; in_data = 5; @(posedge clk); #1;
      in_valid = 0;              @(posedge clk); #1;
      in_valid = 1; in_data = 6; @(posedge clk); #1;
      in_valid = 0;              @(posedge clk); #1;
      check("bubble occ", W'(occupancy), W'(2));
      check("bubble head", out_data, W'(5));
      out_ready = 1; @(posedge clk); #1;
      check("bubble second valid", W'(out_valid), W'(1));
      check("bubble second data", out_data, W'(6));
      @(posedge clk); #1;
      check("bubble empty", W'(out_valid), W'(0));
      out_ready = 0;

      // Randomized traffic against a scoreboard queue
      for (int c = 0; c < 10000; c++) begin
         in_valid  = 1'($urandom_range(0, 1));
         out_ready = 1'($urandom_range(0, 1));
         wdata     = $urandom;
         in_data   = wdata;
         #1;
         exp_irdy = (sb.size() < D) || out_ready;
         check("rnd in_ready", W'(in_ready), W'(exp_irdy));
         if (sb.size() == 0) check("rnd out_valid empty", W'(out_valid), W'(0));
         do_push = in_valid && exp_irdy;
         do_pop  = out_valid && out_ready;
         if (do_pop) begin
            if (sb.size() == 0) check("rnd pop with empty scoreboard", W'(1), W'(0));
            else check("rnd out_data", out_data, sb[0]);
         end
         @(posedge clk); #1;
         if (do_pop && sb.size() > 0) void'(sb.pop_front());
         if (do_push) sb.push_back(wdata);
         check("rnd occupancy", W'(occupancy), W'(sb.size()));
      end

      // Drain everything that is left
      in_valid = 0; out_ready = 1; budget = 0;
      while (sb.size() > 0 && budget < 20) begin
         #1;
         if (out_valid) begin
            check("drain out_data", out_data, sb[0]);
            void'(sb.pop_front());
         end
         @(posedge clk); #1;
         budget++;
      end
      check("drain scoreboard empty", W'(sb.size()), W'(0));
      check("drain occupancy", W'(occupancy), W'(0));

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
